pkt_rr_merge_avlstrm: RTL and testbench
=======================================

// Module: pkt_rr_merge_avlstrm
// PURPOSE
//  Parametrised, packet-atomic N:1 merge of Avalon-ST channels (pkt + per-packet meta + per-packet usr).
//  Successor to the fixed two-way bypass/non-fast-pattern rejoin: NUM_CH sources, round-robin at packet boundaries.
//  Sits after the per-channel FIFOs and feeds a single downstream pkt/meta/usr consumer.
// PARAMETERS
//  NUM_CH   4                 number of input channels, 2..16
//  DW       512               packet data width
//  EW       6                 empty-field width, $clog2(DW/8)
//  META_W   $bits(metadata_t) meta word width
//  USR_W    512               usr word width
//  CNT_W    32                stats counter width
// PORTS
//  Clk            in   1            clock
//  Rst            in   1            synchronous reset, active-high
//  in_valid       in   NUM_CH       per-channel pkt beat valid
//  in_ready       out  NUM_CH       per-channel pkt beat ready
//  in_data        in   NUM_CH*DW    pkt data, channel c at [c*DW +: DW]
//  in_sop/in_eop  in   NUM_CH each  start / end of packet
//  in_empty       in   NUM_CH*EW    empty bytes on eop beat
//  in_meta_valid  in   NUM_CH       meta word valid (one per packet)
//  in_meta_ready  out  NUM_CH       meta consumed
//  in_meta_data   in   NUM_CH*META_W
//  in_usr_valid   in   NUM_CH       usr word valid (one per packet)
//  in_usr_ready   out  NUM_CH
//  in_usr_data    in   NUM_CH*USR_W
//  out_valid/out_ready/out_data/out_sop/out_eop/out_empty   merged pkt stream (out/in/out...)
//  out_meta_valid/out_meta_ready/out_meta_data              merged meta (one per packet)
//  out_usr_valid/out_usr_ready/out_usr_data                 merged usr (one per packet)
//  err_sop        out  1            sticky: non-sop beat seen at a packet boundary
// BEHAVIOUR
//  - Reset: all valid/ready outputs 0, err_sop 0, FSM IDLE, rr pointer -> channel 0 highest priority.
//  - FSM IDLE: eligible(c) = in_valid[c] & in_sop[c] & in_meta_valid[c] & in_usr_valid[c].
//    Grant the first eligible channel at or after rr_ptr (wrapping); rr_ptr <= grant+1 mod NUM_CH; go to XFER.
//    No eligible channel -> stay IDLE; channels with sop but missing meta/usr wait, never partially consumed.
//  - XFER: only granted channel's in_ready follows the output stage; others held 0.
//    Beat on granted channel with in_eop=1 -> IDLE next cycle (single-beat packet: sop&eop, XFER lasts 1 beat).
//  - Meta/usr are popped in the same cycle as the sop beat; they enter their own 1-entry output regs.
//  - Output stage: registered, 1-cycle latency input beat -> out_valid; accept when !out_valid | out_ready.
//    Meta/usr output regs hold until their own ready; a new sop is not granted while either reg is still full.
//  - Non-sop beat at head of a channel while IDLE: beat dropped (in_ready pulsed 1 cycle), err_sop <= 1.
//  - Reset mid-packet: packet truncated, no eop emitted; downstream must be reset together.
//  - Backpressure: out_ready=0 for any duration never drops or duplicates beats; data stable while valid&!ready.
// CONFIGURATION
//  PKT_MERGE_STATS_EN defined: per-channel CNT_W counters of granted packets and of cycles an eligible
//    channel waited ungranted; ports stats_pkt[NUM_CH*CNT_W], stats_wait[NUM_CH*CNT_W]; saturate at max; clear on Rst.
//  Not defined: counters and ports absent; datapath identical.
// STRUCTURE
//  Shared package pkt_merge_pkg: merge_state_e {IDLE,XFER}, stats_t field layout, REG_MERGE_* stats addresses.
//  metadata_t from the existing struct package.
//  Sub-module pkt_rr_arbiter #(NUM_CH): combinational rotating-priority pick + rr_ptr register, one-hot grant.
// TESTING
//  1 NUM_CH=4, all channels send 3-beat packets continuously -> output grant order 0,1,2,3,0...; no interleaving.
//  2 Ch2 sop valid, meta valid, usr absent 10 cycles -> ch2 not granted; ch1 packets pass; ch2 granted on usr arrival.
//  3 Single-beat packets (sop&eop) back-to-back on ch0 only -> one packet per 2 cycles, empty field preserved.
//  4 Random out_ready (50%) over 1000 packets -> scoreboard: bytes, meta, usr per packet match, zero loss.
//  5 Ch3 presents non-sop beat in IDLE -> beat dropped, err_sop=1 and stays 1 until Rst.
//  6 PKT_MERGE_STATS_EN: 5 packets on ch1 while ch0 streams -> stats_pkt[1]=5, stats_wait[1]>0; Rst mid-packet clears all.

Source files
------------

// File: rtl/pkt_merge_pkg.sv
// ============================================================================
//  Module  : pkt_merge_pkg
//  Brief   : Shared types and constants for the round-robin packet merge.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package pkt_merge_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } merge_state_e;

    typedef struct packed {
        logic [15:0] flow_id;
        logic [7:0]  src_port;
        logic [15:0] pkt_len;
        logic [7:0]  flags;
    } metadata_t;

    localparam int STATS_CNT_W = 32;

    // Register-map view of one channel's statistics pair.
    typedef struct packed {
        logic [STATS_CNT_W-1:0] pkt_cnt;
        logic [STATS_CNT_W-1:0] wait_cnt;
    } stats_t;

    localparam logic [7:0] REG_MERGE_STATS_PKT    = 8'h00;
    localparam logic [7:0] REG_MERGE_STATS_WAIT   = 8'h40;
    localparam logic [7:0] REG_MERGE_STATS_STRIDE = 8'h04;

endpackage

`default_nettype wire

// File: rtl/pkt_rr_arbiter.sv
// ============================================================================
//  Module  : pkt_rr_arbiter
//  Brief   : Rotating-priority pick with one-hot grant; pointer moves past the winner.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pkt_rr_arbiter #(
    parameter int NUM_CH = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [NUM_CH-1:0] req,
    output logic [NUM_CH-1:0] grant,
    output logic              any
);

    localparam int PTR_W = $clog2(NUM_CH);

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_idx;
    logic [PTR_W-1:0] w_k;

    always_comb begin
        grant = '0;
        any   = 1'b0;
        w_idx = '0;
        w_k   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_k = PTR_W'((int'(r_ptr) + i) % NUM_CH);
            if (!any && req[w_k]) begin
                any       = 1'b1;
                grant[w_k] = 1'b1;
                w_idx     = w_k;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_ptr <= '0;
        end else if (any) begin
            r_ptr <= (w_idx == PTR_W'(NUM_CH - 1)) ? '0 : w_idx + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pkt_rr_merge_avlstrm.sv
// ============================================================================
//  Module  : pkt_rr_merge_avlstrm
//  Brief   : Packet-atomic N:1 round-robin merge of pkt/meta/usr Avalon-ST channels.
//            Optional per-channel statistics under PKT_MERGE_STATS_EN.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pkt_rr_merge_avlstrm
    import pkt_merge_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DW     = 512,
    parameter int EW     = 6,
    parameter int META_W = $bits(metadata_t),
    parameter int USR_W  = 512,
    parameter int CNT_W  = 32
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic [NUM_CH-1:0]          in_valid,
    output logic [NUM_CH-1:0]          in_ready,
    input  logic [NUM_CH*DW-1:0]       in_data,
    input  logic [NUM_CH-1:0]          in_sop,
    input  logic [NUM_CH-1:0]          in_eop,
    input  logic [NUM_CH*EW-1:0]       in_empty,
    input  logic [NUM_CH-1:0]          in_meta_valid,
    output logic [NUM_CH-1:0]          in_meta_ready,
    input  logic [NUM_CH*META_W-1:0]   in_meta_data,
    input  logic [NUM_CH-1:0]          in_usr_valid,
    output logic [NUM_CH-1:0]          in_usr_ready,
    input  logic [NUM_CH*USR_W-1:0]    in_usr_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DW-1:0]              out_data,
    output logic                       out_sop,
    output logic                       out_eop,
    output logic [EW-1:0]              out_empty,
    output logic                       out_meta_valid,
    input  logic                       out_meta_ready,
    output logic [META_W-1:0]          out_meta_data,
    output logic                       out_usr_valid,
    input  logic                       out_usr_ready,
    output logic [USR_W-1:0]           out_usr_data,
    output logic                       err_sop
`ifdef PKT_MERGE_STATS_EN
    ,
    output logic [NUM_CH*CNT_W-1:0]    stats_pkt,
    output logic [NUM_CH*CNT_W-1:0]    stats_wait
`endif
);

    localparam int SEL_W = $clog2(NUM_CH);

    if (NUM_CH < 2 || NUM_CH > 16 || EW != $clog2(DW / 8) || CNT_W < 1) begin : g_param_check
        $error("pkt_rr_merge_avlstrm: unsupported parameter combination");
    end

    merge_state_e       r_state;
    logic [SEL_W-1:0]   r_sel;
    logic               r_first;
    logic               r_out_valid;
    logic [DW-1:0]      r_out_data;
    logic               r_out_sop;
    logic               r_out_eop;
    logic [EW-1:0]      r_out_empty;
    logic               r_meta_valid;
    logic [META_W-1:0]  r_meta_data;
    logic               r_usr_valid;
    logic [USR_W-1:0]   r_usr_data;
    logic               r_err_sop;

    logic               w_out_accept;
    logic               w_meta_free;
    logic               w_usr_free;
    logic [NUM_CH-1:0]  w_eligible;
    logic [NUM_CH-1:0]  w_req;
    logic [NUM_CH-1:0]  w_grant;
    logic               w_any;
    logic [SEL_W-1:0]   w_grant_idx;
    logic               w_beat_ok;
    logic               w_take;
    logic [NUM_CH-1:0]  w_drop;

    assign w_out_accept = !r_out_valid || out_ready;
    assign w_meta_free  = !r_meta_valid || out_meta_ready;
    assign w_usr_free   = !r_usr_valid || out_usr_ready;
    assign w_eligible   = in_valid & in_sop & in_meta_valid & in_usr_valid;

    // A packet is only started when its meta and usr words are guaranteed a slot.
    assign w_req = (r_state == IDLE && w_meta_free && w_usr_free) ? w_eligible : '0;

    pkt_rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .Clk    (Clk),
        .Rst    (Rst),
        .req    (w_req),
        .grant  (w_grant),
        .any    (w_any)
    );

    always_comb begin
        w_grant_idx = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_grant[c]) w_grant_idx = SEL_W'(c);
        end
    end

    // The sop beat also pops meta/usr, so it additionally needs their slots free.
    assign w_beat_ok = w_out_accept && (!r_first || (w_meta_free && w_usr_free));
    assign w_take    = !Rst && (r_state == XFER) && in_valid[r_sel] && w_beat_ok;
    assign w_drop    = (r_state == IDLE) ? (in_valid & ~in_sop) : '0;

    always_comb begin
        in_ready = '0;
        if (!Rst) begin
            if (r_state == XFER) in_ready[r_sel] = w_beat_ok;
            else                 in_ready        = w_drop;
        end
    end

    always_comb begin
        in_meta_ready = '0;
        in_usr_ready  = '0;
        if (w_take && r_first) begin
            in_meta_ready[r_sel] = 1'b1;
            in_usr_ready[r_sel]  = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state      <= IDLE;
            r_sel        <= '0;
            r_first      <= 1'b0;
            r_out_valid  <= 1'b0;
            r_meta_valid <= 1'b0;
            r_usr_valid  <= 1'b0;
            r_err_sop    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state <= XFER;
                        r_sel   <= w_grant_idx;
                        r_first <= 1'b1;
                    end
                end
                XFER: begin
                    if (w_take) begin
                        r_first <= 1'b0;
                        if (in_eop[r_sel]) r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (|w_drop) r_err_sop <= 1'b1;

            if (w_out_accept) begin
                r_out_valid <= w_take;
                if (w_take) begin
                    r_out_data  <= in_data[r_sel*DW +: DW];
                    r_out_sop   <= in_sop[r_sel];
                    r_out_eop   <= in_eop[r_sel];
                    r_out_empty <= in_empty[r_sel*EW +: EW];
                end
            end

            if (w_take && r_first) begin
                r_meta_valid <= 1'b1;
                r_meta_data  <= in_meta_data[r_sel*META_W +: META_W];
                r_usr_valid  <= 1'b1;
                r_usr_data   <= in_usr_data[r_sel*USR_W +: USR_W];
            end else begin
                if (out_meta_ready) r_meta_valid <= 1'b0;
                if (out_usr_ready)  r_usr_valid  <= 1'b0;
            end
        end
    end

    assign out_valid      = r_out_valid;
    assign out_data       = r_out_data;
    assign out_sop        = r_out_sop;
    assign out_eop        = r_out_eop;
    assign out_empty      = r_out_empty;
    assign out_meta_valid = r_meta_valid;
    assign out_meta_data  = r_meta_data;
    assign out_usr_valid  = r_usr_valid;
    assign out_usr_data   = r_usr_data;
    assign err_sop        = r_err_sop;

`ifdef PKT_MERGE_STATS_EN
    for (genvar c = 0; c < NUM_CH; c++) begin : g_stats
        logic [CNT_W-1:0] r_pkt_cnt;
        logic [CNT_W-1:0] r_wait_cnt;

        // Both counters saturate at all-ones rather than wrapping.
        always_ff @(posedge Clk) begin
            if (Rst) begin
                r_pkt_cnt  <= '0;
                r_wait_cnt <= '0;
            end else begin
                if (w_grant[c] && r_pkt_cnt != '1) r_pkt_cnt <= r_pkt_cnt + 1'b1;
                if (w_eligible[c] && !w_grant[c] && r_wait_cnt != '1)
                    r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end

        assign stats_pkt[c*CNT_W +: CNT_W]  = r_pkt_cnt;
        assign stats_wait[c*CNT_W +: CNT_W] = r_wait_cnt;
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pkt_rr_merge_avlstrm.sv
// ============================================================================
//  Module  : tb_pkt_rr_merge_avlstrm
//  Brief   : Directed, table-driven bench for the round-robin packet merge.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pkt_rr_merge_avlstrm;
    import pkt_merge_pkg::*;

    localparam int NUM_CH = 4;
    localparam int DW     = 32;
    localparam int EW     = 2;
    localparam int META_W = $bits(metadata_t);
    localparam int USR_W  = 16;
    localparam int CNT_W  = 32;

    logic Clk, Rst;
    logic [NUM_CH-1:0]        in_valid, in_ready, in_sop, in_eop;
    logic [NUM_CH*DW-1:0]     in_data;
    logic [NUM_CH*EW-1:0]     in_empty;
    logic [NUM_CH-1:0]        in_meta_valid, in_meta_ready, in_usr_valid, in_usr_ready;
    logic [NUM_CH*META_W-1:0] in_meta_data;
    logic [NUM_CH*USR_W-1:0]  in_usr_data;
    logic                     out_valid, out_ready, out_sop, out_eop;
    logic [DW-1:0]            out_data;
    logic [EW-1:0]            out_empty;
    logic                     out_meta_valid, out_meta_ready, out_usr_valid, out_usr_ready;
    logic [META_W-1:0]        out_meta_data;
    logic [USR_W-1:0]         out_usr_data;
    logic                     err_sop;
`ifdef PKT_MERGE_STATS_EN
    logic [NUM_CH*CNT_W-1:0]  stats_pkt, stats_wait;
`endif

    pkt_rr_merge_avlstrm #(
        .NUM_CH(NUM_CH), .DW(DW), .EW(EW), .META_W(META_W), .USR_W(USR_W), .CNT_W(CNT_W)
    ) dut (
        .Clk(Clk), .Rst(Rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sop(in_sop), .in_eop(in_eop), .in_empty(in_empty),
        .in_meta_valid(in_meta_valid), .in_meta_ready(in_meta_ready), .in_meta_data(in_meta_data),
        .in_usr_valid(in_usr_valid), .in_usr_ready(in_usr_ready), .in_usr_data(in_usr_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sop(out_sop), .out_eop(out_eop), .out_empty(out_empty),
        .out_meta_valid(out_meta_valid), .out_meta_ready(out_meta_ready), .out_meta_data(out_meta_data),
        .out_usr_valid(out_usr_valid), .out_usr_ready(out_usr_ready), .out_usr_data(out_usr_data),
        .err_sop(err_sop)
`ifdef PKT_MERGE_STATS_EN
        , .stats_pkt(stats_pkt), .stats_wait(stats_wait)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [EW-1:0] empty;
    } beat_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [EW-1:0] empty;
        int            cyc;
    } obeat_t;

    typedef struct packed { int id; int len; int emp; } exp_t;
    typedef struct { int ch; int len; int emp; int exp_pos; } vec_t;

    beat_t             src_q    [NUM_CH][$];
    logic [META_W-1:0] meta_src [NUM_CH][$];
    logic [USR_W-1:0]  usr_src  [NUM_CH][$];
    exp_t              exp_q    [NUM_CH][$];
    obeat_t            out_q[$];
    logic [META_W-1:0] meta_o[$];
    logic [USR_W-1:0]  usr_o[$];
    logic [NUM_CH-1:0] hold_usr;
    int                meta_pops [NUM_CH];
    int                cyc;
    int                next_id;
    bit                rand_rdy;
    int                n_checks, n_pass;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic drive_inputs();
        beat_t b;
        for (int c = 0; c < NUM_CH; c++) begin
            b = '0;
            if (src_q[c].size() > 0) b = src_q[c][0];
            in_valid[c]             = (src_q[c].size() > 0);
            in_data[c*DW +: DW]     = b.data;
            in_sop[c]               = b.sop;
            in_eop[c]               = b.eop;
            in_empty[c*EW +: EW]    = b.empty;
            in_meta_valid[c]        = (meta_src[c].size() > 0);
            in_meta_data[c*META_W +: META_W] = (meta_src[c].size() > 0) ? meta_src[c][0] : '0;
            in_usr_valid[c]         = (usr_src[c].size() > 0) && !hold_usr[c];
            in_usr_data[c*USR_W +: USR_W]    = (usr_src[c].size() > 0) ? usr_src[c][0] : '0;
        end
    endtask

    // Sources and monitor: handshakes sampled at negedge, queues advanced just after posedge.
    initial begin : drv_mon
        logic [NUM_CH-1:0] fb, fm, fu;
        bit     prev_stall;
        obeat_t prev_beat;
        prev_stall = 1'b0;
        prev_beat  = '0;
        forever begin
            @(negedge Clk);
            fb = in_valid & in_ready;
            fm = in_meta_valid & in_meta_ready;
            fu = in_usr_valid & in_usr_ready;
            if (prev_stall && !Rst)
                check("stall_hold", {out_valid, out_data, out_sop, out_eop, out_empty},
                      {1'b1, prev_beat.data, prev_beat.sop, prev_beat.eop, prev_beat.empty});
            prev_stall = out_valid && !out_ready;
            prev_beat  = '{out_data, out_sop, out_eop, out_empty, cyc};
            if (out_valid && out_ready) out_q.push_back('{out_data, out_sop, out_eop, out_empty, cyc});
            if (out_meta_valid && out_meta_ready) meta_o.push_back(out_meta_data);
            if (out_usr_valid && out_usr_ready) usr_o.push_back(out_usr_data);
            @(posedge Clk);
            #1;
            cyc++;
            for (int c = 0; c < NUM_CH; c++) begin
                if (fb[c]) void'(src_q[c].pop_front());
                if (fm[c]) begin void'(meta_src[c].pop_front()); meta_pops[c]++; end
                if (fu[c]) void'(usr_src[c].pop_front());
            end
            out_ready      = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
            out_meta_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            out_usr_ready  = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            drive_inputs();
        end
    end

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic send_pkt(input int ch, input int len, input int emp, output int id);
        metadata_t m;
        id = next_id++;
        for (int b = 0; b < len; b++)
            src_q[ch].push_back('{ {4'(ch), 12'(id), 8'(b), 8'h5A}, (b == 0), (b == len - 1),
                                   (b == len - 1) ? EW'(emp) : EW'(0) });
        m = '{flow_id: {4'(ch), 12'(id)}, src_port: 8'(ch), pkt_len: 16'(len), flags: 8'(emp)};
        meta_src[ch].push_back(m);
        usr_src[ch].push_back({4'(ch), 12'(id)});
        exp_q[ch].push_back('{id, len, emp});
    endtask

    function automatic bit srcs_empty();
        for (int c = 0; c < NUM_CH; c++)
            if (src_q[c].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_drain(input int budget);
        int n = 0;
        while (n < budget && !(srcs_empty() && !out_valid && !out_meta_valid && !out_usr_valid)) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check("drain_in_budget", 128'(n < budget), 128'(1));
    endtask

    // Reassembles the next output packet and cross-checks beats, meta and usr among themselves.
    task automatic get_out_pkt(output int ch, output int id, output int len, output int emp, output bit ok);
        obeat_t b;
        metadata_t m;
        logic [USR_W-1:0] u;
        ok = 1'b1; ch = -1; id = -1; len = 0; emp = 0;
        if (out_q.size() == 0 || meta_o.size() == 0 || usr_o.size() == 0) begin
            ok = 1'b0;
            return;
        end
        forever begin
            if (out_q.size() == 0) begin ok = 1'b0; break; end
            b = out_q.pop_front();
            if (len == 0) begin
                if (!b.sop) ok = 1'b0;
                ch = int'(b.data[31:28]);
                id = int'(b.data[27:16]);
            end else if (b.sop) ok = 1'b0;
            if (int'(b.data[31:28]) != ch || int'(b.data[27:16]) != id ||
                int'(b.data[15:8]) != len || b.data[7:0] != 8'h5A) ok = 1'b0;
            len++;
            if (b.eop) begin emp = int'(b.empty); break; end
        end
        m = metadata_t'(meta_o.pop_front());
        u = usr_o.pop_front();
        if (m.flow_id != {4'(ch), 12'(id)} || m.pkt_len != 16'(len) || m.flags != 8'(emp)) ok = 1'b0;
        if (u != {4'(ch), 12'(id)}) ok = 1'b0;
    endtask

    task automatic clear_all();
        for (int c = 0; c < NUM_CH; c++) begin
            src_q[c].delete(); meta_src[c].delete(); usr_src[c].delete(); exp_q[c].delete();
        end
        out_q.delete(); meta_o.delete(); usr_o.delete();
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : main
        vec_t t1 [8];
        int   t1_id [8];
        int   ch, id, len, emp, tmp, mp;
        bit   ok;
        int   ids2 [3];

        t1[0] = '{0, 3, 0, 0}; t1[1] = '{1, 3, 1, 1}; t1[2] = '{2, 3, 2, 2}; t1[3] = '{3, 3, 3, 3};
        t1[4] = '{0, 3, 1, 4}; t1[5] = '{1, 3, 2, 5}; t1[6] = '{2, 3, 3, 6}; t1[7] = '{3, 3, 0, 7};

        n_checks = 0; n_pass = 0; cyc = 0; next_id = 0; rand_rdy = 1'b0; hold_usr = '0;
        for (int c = 0; c < NUM_CH; c++) meta_pops[c] = 0;
        Rst = 1'b1;
        out_ready = 1'b1; out_meta_ready = 1'b1; out_usr_ready = 1'b1;
        drive_inputs();

        // Reset state
        repeat (3) tick();
        check("rst_out_valid", 128'(out_valid), 0);
        check("rst_side_valid", 128'({out_meta_valid, out_usr_valid}), 0);
        check("rst_in_ready", 128'({in_ready, in_meta_ready, in_usr_ready}), 0);
        check("rst_err_sop", 128'(err_sop), 0);
        Rst = 1'b0;
        tick();

        // Round-robin order with continuous 3-beat packets on all channels
        for (int i = 0; i < 8; i++) send_pkt(t1[i].ch, t1[i].len, t1[i].emp, t1_id[i]);
        wait_drain(200);
        for (int p = 0; p < 8; p++) begin
            get_out_pkt(ch, id, len, emp, ok);
            for (int i = 0; i < 8; i++) begin
                if (t1[i].exp_pos == p) begin
                    check("t1_order", {32'(ch), 32'(id)}, {32'(t1[i].ch), 32'(t1_id[i])});
                    check("t1_pkt", {31'(0), ok, 32'(len), 32'(emp)}, {31'(0), 1'b1, 32'(t1[i].len), 32'(t1[i].emp)});
                end
            end
        end
        clear_all();

        // Channel 2 waits for its usr word while channel 1 keeps flowing
        hold_usr[2] = 1'b1;
        mp = meta_pops[2];
        send_pkt(2, 2, 1, ids2[2]);
        send_pkt(1, 3, 0, ids2[0]);
        send_pkt(1, 3, 2, ids2[1]);
        repeat (10) tick();
        check("t2_ch2_meta_held", 128'(meta_pops[2] - mp), 0);
        check("t2_ch2_beats_held", 128'(src_q[2].size()), 128'(2));
        hold_usr[2] = 1'b0;
        wait_drain(200);
        for (int p = 0; p < 3; p++) begin
            get_out_pkt(ch, id, len, emp, ok);
            check("t2_order", {31'(0), ok, 32'(ch), 32'(id)},
                  {31'(0), 1'b1, 32'((p == 2) ? 2 : 1), 32'(ids2[p])});
        end
        clear_all();

        // Back-to-back single-beat packets: one every two cycles, empty preserved
        for (int i = 0; i < 6; i++) send_pkt(0, 1, i % 4, tmp);
        wait_drain(200);
        check("t3_beats", 128'(out_q.size()), 128'(6));
        for (int i = 1; i < 6 && i < out_q.size(); i++)
            check("t3_spacing", 128'(out_q[i].cyc - out_q[i-1].cyc), 128'(2));
        for (int i = 0; i < 6; i++) begin
            get_out_pkt(ch, id, len, emp, ok);
            check("t3_pkt", {31'(0), ok, 32'(ch), 32'(len), 32'(emp)},
                  {31'(0), 1'b1, 32'(0), 32'(1), 32'(i % 4)});
        end
        clear_all();

        // Random backpressure over 1000 packets, scoreboarded per channel
        rand_rdy = 1'b1;
        for (int i = 0; i < 1000; i++)
            send_pkt($urandom_range(0, NUM_CH - 1), $urandom_range(1, 4), $urandom_range(0, 3), tmp);
        wait_drain(40000);
        for (int i = 0; i < 1000; i++) begin
            exp_t e;
            get_out_pkt(ch, id, len, emp, ok);
            e = '{-2, 0, 0};
            if (ch >= 0 && ch < NUM_CH && exp_q[ch].size() > 0) e = exp_q[ch].pop_front();
            check("t4_pkt", {31'(0), ok, 32'(id), 32'(len), 32'(emp)},
                  {31'(0), 1'b1, 32'(e.id), 32'(e.len), 32'(e.emp)});
        end
        check("t4_no_extra", 128'(out_q.size() + meta_o.size() + usr_o.size()), 0);
        rand_rdy = 1'b0;
        tick();
        clear_all();

        // Non-sop beat at a boundary is dropped and flags a sticky error
        src_q[3].push_back('{32'hDEAD_0000, 1'b0, 1'b1, EW'(0)});
        repeat (4) tick();
        check("t5_dropped", 128'(src_q[3].size()), 0);
        check("t5_no_output", 128'(out_q.size()), 0);
        check("t5_err_set", 128'(err_sop), 128'(1));
        send_pkt(3, 2, 3, tmp);
        send_pkt(0, 1, 1, tmp);
        wait_drain(200);
        for (int p = 0; p < 2; p++) begin
            get_out_pkt(ch, id, len, emp, ok);
            check("t5_after_pkt", 128'(ok), 128'(1));
        end
        check("t5_err_sticky", 128'(err_sop), 128'(1));
        Rst = 1'b1;
        repeat (2) tick();
        Rst = 1'b0;
        tick();
        check("t5_err_cleared", 128'(err_sop), 0);
        clear_all();

`ifdef PKT_MERGE_STATS_EN
        // Statistics: grants and waiting cycles, cleared by a mid-packet reset
        for (int i = 0; i < 8; i++) send_pkt(0, 3, 0, tmp);
        for (int i = 0; i < 5; i++) send_pkt(1, 2, 0, tmp);
        wait_drain(400);
        check("st_pkt1", 128'(stats_pkt[1*CNT_W +: CNT_W]), 128'(5));
        check("st_pkt0", 128'(stats_pkt[0*CNT_W +: CNT_W]), 128'(8));
        check("st_wait1_nonzero", 128'(stats_wait[1*CNT_W +: CNT_W] != 0), 128'(1));
        send_pkt(0, 4, 0, tmp);
        repeat (3) tick();
        Rst = 1'b1;
        clear_all();
        repeat (2) tick();
        Rst = 1'b0;
        tick();
        check("st_cleared", 128'({stats_pkt, stats_wait}), 0);
        check("st_rst_idle", 128'(out_valid), 0);
        clear_all();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
